fc_classifier: RTL
==================

Name: fc_classifier

Overview:
- Fully-connected classification stage directly downstream of the conv/max-pool/ReLU feature layer.
- Consumes the pooled feature maps as a stream: one beat per spatial position, carrying CH channel values.
- Multiply-accumulates the stream against a writable weight RAM into NCLS class accumulators.
- Emits the NCLS requantised scores serially, then the argmax class index.

Parameters:
- CH, 10, channels per input beat (one value per feature map)
- FEAT, 36, beats per frame (pooled map size, 6x6)
- NCLS, 10, number of output classes
- DW, 13, signed data width of features and scores
- WW, 8, signed weight width
- ACC_W, 32, signed accumulator width
- SHIFT, 8, arithmetic right shift applied to accumulators before saturation

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input beat strobe
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  CH*DW  channel values, ch0 in bits [DW-1:0], signed
- w_wr  in  1  weight write strobe
- w_addr  in  clog2(NCLS*FEAT*CH)  flat weight address = (cls*FEAT + feat)*CH + ch
- w_data  in  WW  signed weight
- score_valid  out  1  score output strobe
- score  out  DW  signed requantised class score
- score_idx  out  clog2(NCLS)  class index of score
- class_id  out  clog2(NCLS)  argmax result, valid when done=1
- done  out  1  one-cycle frame-complete pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-low, ports named clk and rst.
- Reset (rst=0 sampled on edge):
  - State returns to IDLE.
  - All accumulators and the beat counter clear.
  - in_ready=1; score_valid, score, score_idx, class_id and done all 0.
  - Weight RAM is not cleared.
  - Reset mid-frame abandons the frame; no scores are emitted.
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches in_data, sets beat=0 and moves to MAC.
  - MAC: in_ready=0. Runs NCLS cycles, cls=0..NCLS-1. Each cycle, acc[cls] += sum over ch of feat[ch]*W[cls][beat][ch]. All products are full-precision signed (DW+WW bits); the sum is sign-extended to ACC_W.
    - After cls=NCLS-1: if beat==FEAT-1, go to OUT; otherwise increment beat and go to WAIT.
  - WAIT: in_ready=1. A handshake latches the next beat and goes to MAC. Per-beat latency is NCLS cycles of MAC plus at least 1 cycle in WAIT, so in_ready pulses low for exactly NCLS cycles per accepted beat.
  - OUT: NCLS cycles, score_valid=1, score_idx=0..NCLS-1, score=sat_DW(acc[idx] >>> SHIFT).
    - Saturation limits are -2^(DW-1) and 2^(DW-1)-1 (-4096 and 4095 at default).
    - A running max is tracked over the saturated scores; ties keep the lower index.
  - DONE: one cycle. done=1 and class_id=argmax. Accumulators clear; the block returns to IDLE.
    - class_id holds until the next DONE or reset.
- in_valid while in_ready=0 is ignored and the beat is lost; the upstream stage must hold data until the handshake.
- Weight writes:
  - Accepted only in IDLE with beat count 0; ignored in all other states.
  - An address >= NCLS*FEAT*CH is ignored.
  - A write takes effect for the next frame.
- Accumulator overflow wraps at ACC_W. ACC_W=32 is guaranteed not to overflow for the default parameters.
- Frame length is fixed at FEAT beats; there is no early-termination input.

Test Plan:
- Unity path: W[c][f][ch]=1 only for ch==c, all others 0; every beat has ch value = 16*(c+1); SHIFT=0 → score[c]=min(36*16*(c+1), 4095), i.e. 576, 1152, ... with c>=7 saturating to 4095; class_id=7 (lowest of the tied 4095s); done pulses once.
- Negative/saturation: all weights -128, all features 4095, SHIFT=8 → acc = -128*4095*10*36 = -188697600, shifted = -737100 → every score = -4096; class_id=0 (all tie).
- Handshake: hold in_valid=1 continuously → exactly 36 beats accepted; in_ready low for 10 cycles after each accept; the beat value presented during in_ready=0 is verified not to be accumulated.
- Weight write gating: w_wr during MAC with a new value → ignored, frame result unchanged; the same write in IDLE before the next frame → changes that frame's result.
- Reset mid-frame: drive rst=0 after beat 20 → no score_valid, no done, in_ready=1; a following full frame produces scores identical to a clean run.
- Back-to-back frames: the second frame's scores are independent of the first, showing the accumulators cleared at DONE.

Source files
------------

// File: rtl/fc_classifier.sv
// fc_classifier: fully-connected stage; MACs a CH-channel beat stream against a weight RAM into NCLS accumulators.
// Latency: NCLS MAC cycles per accepted beat; after the last beat NCLS score cycles then a one-cycle done pulse.
// Backpressure: in_ready is high only in IDLE/WAIT; in_valid while in_ready is low is dropped.
module fc_classifier #(
    parameter int CH    = 10,
    parameter int FEAT  = 36,
    parameter int NCLS  = 10,
    parameter int DW    = 13,
    parameter int WW    = 8,
    parameter int ACC_W = 32,
    parameter int SHIFT = 8,
    localparam int AW   = $clog2(NCLS*FEAT*CH),
    localparam int CW   = $clog2(NCLS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH*DW-1:0]   in_data,
    input  logic               w_wr,
    input  logic [AW-1:0]      w_addr,
    input  logic [WW-1:0]      w_data,
    output logic               score_valid,
    output logic [DW-1:0]      score,
    output logic [CW-1:0]      score_idx,
    output logic [CW-1:0]      class_id,
    output logic               done
);

    localparam int BW     = $clog2(FEAT);
    localparam int PW     = DW + WW;
    localparam int NW     = NCLS * FEAT * CH;
    localparam int SMAX_I = 2**(DW-1) - 1;
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(SMAX_I);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-SMAX_I - 1);
    localparam logic [CW-1:0] LAST_CLS  = CW'(NCLS - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FEAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_WAIT, S_OUT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [CW-1:0]            cls_q, cls_d;
    logic [CH*DW-1:0]         feat_q, feat_d;
    logic signed [ACC_W-1:0]  acc_q [NCLS];
    logic signed [ACC_W-1:0]  acc_d [NCLS];
    logic signed [DW-1:0]     max_q, max_d;
    logic [CW-1:0]            arg_q, arg_d;
    logic [CW-1:0]            class_id_q, class_id_d;

    logic signed [WW-1:0]     w_mem [NW];

    logic [AW-1:0]            row_base;
    logic signed [PW-1:0]     fx, wx, prod;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DW-1:0]     sat_score;

    // Weight RAM: element writes only while idle between frames; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr && state_q == S_IDLE && beat_q == '0 && w_addr < AW'(NW)) begin
            w_mem[w_addr] <= w_data;
        end
    end

    // Dot product of the latched beat with the weight row selected by (cls, beat).
    always_comb begin
        row_base = (AW'(cls_q) * AW'(FEAT) + AW'(beat_q)) * AW'(CH);
        mac_sum  = '0;
        fx       = '0;
        wx       = '0;
        prod     = '0;
        for (int ch = 0; ch < CH; ch++) begin
            fx      = PW'($signed(feat_q[ch*DW +: DW]));
            wx      = PW'(w_mem[row_base + AW'(ch)]);
            prod    = fx * wx;
            mac_sum = mac_sum + ACC_W'(prod);
        end
    end

    // Requantise the accumulator being emitted: arithmetic shift, then clamp to DW bits.
    always_comb begin
        shifted = acc_q[cls_q] >>> SHIFT;
        if (shifted > SMAX) begin
            sat_score = DW'(SMAX);
        end else if (shifted < SMIN) begin
            sat_score = DW'(SMIN);
        end else begin
            sat_score = DW'(shifted);
        end
    end

    // Frame sequencer: accept beat, sweep classes, emit scores with running argmax, then clear.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cls_d       = cls_q;
        feat_d      = feat_q;
        acc_d       = acc_q;
        max_d       = max_q;
        arg_d       = arg_q;
        class_id_d  = class_id_q;
        in_ready    = 1'b0;
        score_valid = 1'b0;
        score       = '0;
        score_idx   = '0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    feat_d  = in_data;
                    beat_d  = '0;
                    cls_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d[cls_q] = acc_q[cls_q] + mac_sum;
                if (cls_q == LAST_CLS) begin
                    cls_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_OUT;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    cls_d = cls_q + 1'b1;
                end
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    feat_d  = in_data;
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                score_valid = 1'b1;
                score_idx   = cls_q;
                score       = sat_score;
                // Strict compare so ties keep the lower class index.
                if (cls_q == '0 || sat_score > max_q) begin
                    max_d = sat_score;
                    arg_d = cls_q;
                end
                if (cls_q == LAST_CLS) begin
                    class_id_d = arg_d;
                    cls_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    cls_d = cls_q + 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
                for (int i = 0; i < NCLS; i++) begin
                    acc_d[i] = '0;
                end
                beat_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            cls_q      <= '0;
            feat_q     <= '0;
            max_q      <= '0;
            arg_q      <= '0;
            class_id_q <= '0;
            for (int i = 0; i < NCLS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cls_q      <= cls_d;
            feat_q     <= feat_d;
            max_q      <= max_d;
            arg_q      <= arg_d;
            class_id_q <= class_id_d;
            for (int i = 0; i < NCLS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign class_id = class_id_q;

endmodule
